// File: rtl/full_sub_bist.sv
// full_sub_bist -- built-in self-test engine for a combinational full subtractor.
//
// Sweeps all eight {a,b,c} vectors into the subtractor, holds each for
// SETTLE_CYCLES cycles, and then samples {diff,bout} back. The sampled pair is
// compared with the golden subtraction. Mismatches are counted, saturating at
// 255, and the first failing vector is recorded. The full sweep is repeated
// PASSES times.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               run request (accepted in IDLE or DONE)
//   dut_a/dut_b/dut_c   registered stimulus to the subtractor
//   dut_diff/dut_bout   subtractor response
//   busy                run in progress
//   done                run complete, held until the next accepted start
//   pass                with done: no mismatches this run
//   err_count           mismatching vector count, saturating at 255
//   fail_valid          at least one mismatch seen this run
//   fail_vec            {a,b,c} of the first mismatching vector
//   fail_obs            {diff,bout} observed at the first mismatch
module full_sub_bist #(
   parameter int SETTLE_CYCLES = 2,
   parameter int PASSES        = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       dut_a,
   output logic       dut_b,
   output logic       dut_c,
   input  logic       dut_diff,
   input  logic       dut_bout,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic       fail_valid,
   output logic [2:0] fail_vec,
   output logic [1:0] fail_obs
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [7:0]  PASS_LAST   = 8'(PASSES - 1);

   state_t      state;
   logic [2:0]  vec;
   logic [7:0]  pass_cnt;
   logic [15:0] settle_cnt;
   logic [1:0]  obs;
   logic        mismatch;

   // Golden full-subtractor result, packed as {diff,bout}.
   function automatic logic [1:0] golden(input logic [2:0] v);
      logic a, b, c;
      a = v[2];
      b = v[1];
      c = v[0];
      golden = {a ^ b ^ c, (~a & b) | (~a & c) | (b & c)};
   endfunction

   // Saturating increment for the error counter.
   function automatic logic [7:0] sat_inc(input logic [7:0] x);
      sat_inc = (x == 8'hFF) ? x : x + 8'd1;
   endfunction

   // The stimulus is the vector register itself. In DONE it rests at 111.
   assign dut_a = vec[2];
   assign dut_b = vec[1];
   assign dut_c = vec[0];

   assign obs      = {dut_diff, dut_bout};
   assign mismatch = (obs != golden(vec));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         vec        <= 3'd0;
         pass_cnt   <= 8'd0;
         settle_cnt <= 16'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= 8'd0;
         fail_valid <= 1'b0;
         fail_vec   <= 3'd0;
         fail_obs   <= 2'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= DRIVE;
                  vec        <= 3'd0;
                  pass_cnt   <= 8'd0;
                  settle_cnt <= 16'd0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_count  <= 8'd0;
                  fail_valid <= 1'b0;
                  fail_vec   <= 3'd0;
                  fail_obs   <= 2'd0;
               end
            end

            // Hold the vector for SETTLE_CYCLES cycles before sampling.
            DRIVE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  settle_cnt <= 16'd0;
                  state      <= CHECK;
               end else begin
                  settle_cnt <= settle_cnt + 16'd1;
               end
            end

            // Sample on this closing edge. The next vector is driven from the same edge.
            CHECK: begin
               if (mismatch) begin
                  err_count <= sat_inc(err_count);
                  if (!fail_valid) begin
                     fail_valid <= 1'b1;
                     fail_vec   <= vec;
                     fail_obs   <= obs;
                  end
               end
               if (vec == 3'd7 && pass_cnt == PASS_LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  // The last sample's verdict is not in err_count yet.
                  pass  <= (err_count == 8'd0) && !mismatch;
               end else begin
                  if (vec == 3'd7) pass_cnt <= pass_cnt + 8'd1;
                  vec   <= vec + 3'd1;
                  state <= DRIVE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
